control_pipe_regs: RTL and testbench
====================================

Name: control_pipe_regs

Overview:
Carries the main decoder's control word from Decode through Execute, Memory and Writeback, and attaches a destination register and a valid bit to each stage. It resolves branches in Execute (PCSrcE) and inserts bubbles on flush. It also counts retired and squashed instructions. It sits between the main/ALU decoders and the datapath stage registers of the pipelined core.

Parameters:
CNT_W, 32, width of the retired and squashed instruction counters (wrap-around, no saturation)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active low
ValidD  input  1  instruction in Decode is real (not a fetch bubble)
RegWriteD  input  1  decoder RegWrite
MemWriteD  input  1  decoder MemWrite
ResultSrcD  input  1  decoder ResultSrc (1 = load data)
ALUSrcD  input  1  decoder ALUSrc
BranchD  input  1  decoder Branch
ALUOpD  input  2  decoder ALUOp
RdD  input  5  destination register from instr[11:7]
FlushE  input  1  external flush of the Decode-to-Execute transfer (e.g. load-use hazard)
ZeroE  input  1  ALU zero flag in Execute
RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE  output  1 each  Execute-stage controls
ALUOpE  output  2  Execute-stage ALUOp
RdE  output  5  Execute-stage rd
PCSrcE  output  1  branch taken, combinational
RegWriteM, MemWriteM, ResultSrcM  output  1 each  Memory-stage controls
RdM  output  5  Memory-stage rd
RegWriteW, ResultSrcW  output  1 each  Writeback-stage controls
RdW  output  5  Writeback-stage rd
ValidE, ValidM, ValidW  output  1 each  stage occupancy
RetireCnt  output  CNT_W  instructions retired from Writeback
SquashCnt  output  CNT_W  valid Decode instructions discarded by a bubble

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0, including both counters. PCSrcE is therefore 0. Reset asserted mid-stream discards all in-flight state immediately. The first edge after rst deasserts captures normally.
- Bubble: valid=0, every control bit 0, ALUOp=00, rd=0. A bubble never writes memory or the register file.
- PCSrcE = BranchE & ZeroE & ValidE. This is purely combinational, with no register delay.
- E load, each rising edge:
  - BubbleE = FlushE | PCSrcE | ~ValidD.
  - If BubbleE, E loads a bubble.
  - Otherwise E loads {RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD, ALUOpD, RdD} and ValidE=1.
- M load, each edge: {RegWriteM, MemWriteM, ResultSrcM, RdM, ValidM} <= {RegWriteE, MemWriteE, ResultSrcE, RdE, ValidE}. There is no stall or flush at M, so an instruction in E always advances. This includes the branch that caused PCSrcE.
- W load, each edge: {RegWriteW, ResultSrcW, RdW, ValidW} <= M-stage equivalents.
- Latency: a valid Decode instruction appears in E 1 cycle later, in M 2 cycles later, and in W 3 cycles later.
- RegWrite with rd=0: propagated unchanged. The register file ignores x0; this block does not mask it.
- RetireCnt: +1 on every edge where ValidW=1. The count reflects instructions that have left W. Wraps from 2^CNT_W-1 to 0.
- SquashCnt: +1 on every edge where ValidD=1 and (FlushE | PCSrcE).
  - FlushE and PCSrcE asserted together still count once.
  - ~ValidD alone never counts.
  - Wraps like RetireCnt.
- Unknown or illegal opcodes: the decoder drives all-zero controls. These pass through as a valid no-op and still retire.

Test Plan:
1. Reset and fill:
   - Stimulus: hold rst=0 for 2 cycles, then release.
   - Required: all outputs 0 during reset.
   - Stimulus: then feed ValidD=1, R-type (RegWriteD=1, ALUOpD=10, RdD=5) for 1 cycle, then ValidD=0.
   - Required: RegWriteE=1/RdE=5 at cycle 1, RegWriteM=1 at cycle 2, RegWriteW=1/RdW=5 at cycle 3; RetireCnt=1 after cycle 4.
2. Taken branch:
   - Stimulus: feed beq (BranchD=1, ALUOpD=01) and then an sw (MemWriteD=1) back-to-back; drive ZeroE=1 while beq is in E.
   - Required: PCSrcE=1 in that same cycle; the sw never appears (MemWriteE=0, ValidE=0 next cycle); SquashCnt=1; beq still reaches W; RetireCnt=1.
3. Not-taken branch:
   - Stimulus: same sequence as scenario 2 with ZeroE=0.
   - Required: PCSrcE=0; the sw reaches M with MemWriteM=1; SquashCnt=0; RetireCnt=2.
4. External flush:
   - Stimulus: lw (RegWriteD=1, ResultSrcD=1, ALUSrcD=1, RdD=7) with FlushE=1 in the same cycle.
   - Required: E takes a bubble (all 0); SquashCnt increments by 1.
   - Stimulus: repeat with ValidD=0.
   - Required: SquashCnt unchanged.
5. Simultaneous flush and branch:
   - Stimulus: FlushE=1 while PCSrcE=1 and ValidD=1.
   - Required: single bubble in E; SquashCnt +1 only.
6. Reset mid-stream and wrap:
   - Stimulus: assert rst with 3 valid instructions in flight.
   - Required: ValidE/M/W drop to 0 immediately (before the next edge).
   - Stimulus: with CNT_W=4, retire 16 instructions.
   - Required: RetireCnt reads 0.

Source files
------------

// File: rtl/control_pipe_regs.sv
// Control-side pipeline registers for the five-stage core.
// Carries the decoder control word from Decode through Execute, Memory and
// Writeback with a destination register and valid bit per stage. Branches
// are resolved in Execute. Bubbles replace the instruction entering Execute
// on flush. Retired and squashed instructions are counted.
module control_pipe_regs #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ResultSrcD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic [1:0]       ALUOpD,
  input  logic [4:0]       RdD,
  input  logic             FlushE,
  input  logic             ZeroE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ResultSrcE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic [1:0]       ALUOpE,
  output logic [4:0]       RdE,
  output logic             PCSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [4:0]       RdM,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic [4:0]       RdW,
  output logic             ValidE,
  output logic             ValidM,
  output logic             ValidW,
  output logic [CNT_W-1:0] RetireCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  // Execute keeps the full control word; later stages keep only what they use.
  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memWrite;
    logic       resultSrc;
    logic       aluSrc;
    logic       branch;
    logic [1:0] aluOp;
    logic [4:0] rd;
  } exStageT;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memWrite;
    logic       resultSrc;
    logic [4:0] rd;
  } memStageT;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       resultSrc;
    logic [4:0] rd;
  } wbStageT;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  exStageT          exReg;
  exStageT          exNext;
  memStageT         memReg;
  wbStageT          wbReg;
  logic             branchTaken;
  logic             bubbleE;
  logic             squashEvent;
  logic [CNT_W-1:0] retireReg;
  logic [CNT_W-1:0] squashReg;

  // The branch decision must reach the fetch mux in the same cycle, so it is
  // formed straight from the Execute register with no extra delay.
  assign branchTaken = exReg.branch & ZeroE & exReg.valid;

  // A bubble enters Execute on flush, on a taken branch (the younger
  // instruction is wrong-path) or when Decode holds nothing real.
  assign bubbleE     = FlushE | branchTaken | ~ValidD;

  // Only a real Decode instruction that gets discarded counts as squashed;
  // flush and taken branch together still discard just one instruction.
  assign squashEvent = ValidD & (FlushE | branchTaken);

  // Build the next Execute contents: a bubble unless Decode can advance.
  always_comb begin
    exNext = '0;
    if (!bubbleE) begin
      exNext.valid     = 1'b1;
      exNext.regWrite  = RegWriteD;
      exNext.memWrite  = MemWriteD;
      exNext.resultSrc = ResultSrcD;
      exNext.aluSrc    = ALUSrcD;
      exNext.branch    = BranchD;
      exNext.aluOp     = ALUOpD;
      exNext.rd        = RdD;
    end
  end

  // Execute stage register; reset empties it immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exReg <= '0;
    end else begin
      exReg <= exNext;
    end
  end

  // Memory stage register; whatever sits in Execute always moves on,
  // including the branch that redirected fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memReg <= '0;
    end else begin
      memReg.valid     <= exReg.valid;
      memReg.regWrite  <= exReg.regWrite;
      memReg.memWrite  <= exReg.memWrite;
      memReg.resultSrc <= exReg.resultSrc;
      memReg.rd        <= exReg.rd;
    end
  end

  // Writeback stage register, fed unconditionally from Memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbReg <= '0;
    end else begin
      wbReg.valid     <= memReg.valid;
      wbReg.regWrite  <= memReg.regWrite;
      wbReg.resultSrc <= memReg.resultSrc;
      wbReg.rd        <= memReg.rd;
    end
  end

  // Retire counter: an instruction retires on the edge it leaves Writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retireReg <= '0;
    end else if (wbReg.valid) begin
      retireReg <= retireReg + CNT_ONE;
    end
  end

  // Squash counter: one per real Decode instruction replaced by a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      squashReg <= '0;
    end else if (squashEvent) begin
      squashReg <= squashReg + CNT_ONE;
    end
  end

  assign ValidE     = exReg.valid;
  assign RegWriteE  = exReg.regWrite;
  assign MemWriteE  = exReg.memWrite;
  assign ResultSrcE = exReg.resultSrc;
  assign ALUSrcE    = exReg.aluSrc;
  assign BranchE    = exReg.branch;
  assign ALUOpE     = exReg.aluOp;
  assign RdE        = exReg.rd;
  assign PCSrcE     = branchTaken;

  assign ValidM     = memReg.valid;
  assign RegWriteM  = memReg.regWrite;
  assign MemWriteM  = memReg.memWrite;
  assign ResultSrcM = memReg.resultSrc;
  assign RdM        = memReg.rd;

  assign ValidW     = wbReg.valid;
  assign RegWriteW  = wbReg.regWrite;
  assign ResultSrcW = wbReg.resultSrc;
  assign RdW        = wbReg.rd;

  assign RetireCnt  = retireReg;
  assign SquashCnt  = squashReg;

endmodule

// File: tb/tb_control_pipe_regs.sv
// Directed, table-driven bench for control_pipe_regs with 4-bit counters so
// counter wrap is reachable quickly.
module tb_control_pipe_regs;

  localparam int CNT_W = 4;

  // Control words ordered {RegWrite, MemWrite, ResultSrc, ALUSrc, Branch, ALUOp}
  localparam logic [6:0] NOP    = 7'b000_0000;
  localparam logic [6:0] R_TYPE = 7'b100_0010;
  localparam logic [6:0] BEQ    = 7'b000_0101;
  localparam logic [6:0] SW     = 7'b010_1000;
  localparam logic [6:0] LW     = 7'b101_1000;

  localparam logic [12:0] E0 = 13'h0;
  localparam logic [8:0]  M0 = 9'h0;
  localparam logic [7:0]  W0 = 8'h0;

  logic             clk;
  logic             rst;
  logic             ValidD, RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD;
  logic [1:0]       ALUOpD;
  logic [4:0]       RdD;
  logic             FlushE, ZeroE;
  logic             RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
  logic [1:0]       ALUOpE;
  logic [4:0]       RdE;
  logic             PCSrcE;
  logic             RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]       RdM;
  logic             RegWriteW, ResultSrcW;
  logic [4:0]       RdW;
  logic             ValidE, ValidM, ValidW;
  logic [CNT_W-1:0] RetireCnt, SquashCnt;

  logic [12:0] actE;
  logic [8:0]  actM;
  logic [7:0]  actW;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vd;
    logic [6:0]  ctl;
    logic [4:0]  rd;
    logic        flush;
    logic        zero;
    logic        pc;
    logic [12:0] eExp;
    logic [8:0]  mExp;
    logic [7:0]  wExp;
    logic [3:0]  ret;
    logic [3:0]  sq;
  } vecT;

  vecT vecQ[$];

  control_pipe_regs #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .ResultSrcD(ResultSrcD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
    .ALUOpD(ALUOpD), .RdD(RdD), .FlushE(FlushE), .ZeroE(ZeroE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUOpE(ALUOpE), .RdE(RdE),
    .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
    .RetireCnt(RetireCnt), .SquashCnt(SquashCnt)
  );

  assign actE = {ValidE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUOpE, RdE};
  assign actM = {ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM};
  assign actW = {ValidW, RegWriteW, ResultSrcW, RdW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything wedges the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [12:0] eRec(input logic v, input logic [6:0] c, input logic [4:0] r);
    return {v, c, r};
  endfunction

  function automatic logic [8:0] mRec(input logic v, input logic [6:0] c, input logic [4:0] r);
    return {v, c[6], c[5], c[4], r};
  endfunction

  function automatic logic [7:0] wRec(input logic v, input logic [6:0] c, input logic [4:0] r);
    return {v, c[6], c[4], r};
  endfunction

  function automatic void addVec(input logic vd, input logic [6:0] ctl, input logic [4:0] rd,
                                 input logic flush, input logic zero, input logic pc,
                                 input logic [12:0] e, input logic [8:0] m, input logic [7:0] w,
                                 input logic [3:0] ret, input logic [3:0] sq);
    vecT v;
    v.vd = vd; v.ctl = ctl; v.rd = rd; v.flush = flush; v.zero = zero; v.pc = pc;
    v.eExp = e; v.mExp = m; v.wExp = w; v.ret = ret; v.sq = sq;
    vecQ.push_back(v);
  endfunction

  task automatic checkOutput(input string what, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", what, actual, expected);
    end
  endtask

  task automatic driveD(input logic vd, input logic [6:0] ctl, input logic [4:0] rd,
                        input logic flush, input logic zero);
    ValidD = vd;
    {RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD, ALUOpD} = ctl;
    RdD    = rd;
    FlushE = flush;
    ZeroE  = zero;
  endtask

  // Drive one vector, check the combinational branch decision before the
  // edge, then check every stage and both counters just after it.
  task automatic applyStimulus(input int idx, input vecT v);
    @(negedge clk);
    driveD(v.vd, v.ctl, v.rd, v.flush, v.zero);
    #1;
    checkOutput($sformatf("v%0d.PCSrcE", idx), {15'b0, PCSrcE}, {15'b0, v.pc});
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d.E", idx), {3'b0, actE}, {3'b0, v.eExp});
    checkOutput($sformatf("v%0d.M", idx), {7'b0, actM}, {7'b0, v.mExp});
    checkOutput($sformatf("v%0d.W", idx), {8'b0, actW}, {8'b0, v.wExp});
    checkOutput($sformatf("v%0d.Retire", idx), {12'b0, RetireCnt}, {12'b0, v.ret});
    checkOutput($sformatf("v%0d.Squash", idx), {12'b0, SquashCnt}, {12'b0, v.sq});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".E"}, {3'b0, actE}, 16'h0);
    checkOutput({tag, ".M"}, {7'b0, actM}, 16'h0);
    checkOutput({tag, ".W"}, {8'b0, actW}, 16'h0);
    checkOutput({tag, ".PCSrcE"}, {15'b0, PCSrcE}, 16'h0);
    checkOutput({tag, ".Retire"}, {12'b0, RetireCnt}, 16'h0);
    checkOutput({tag, ".Squash"}, {12'b0, SquashCnt}, 16'h0);
  endtask

  initial begin
    // vd ctl rd flush zero | pc E M W retire squash
    // Reset and fill: one R-type walks E -> M -> W then retires
    addVec(1, R_TYPE, 5, 0, 0, 0, eRec(1, R_TYPE, 5), M0, W0, 0, 0);
    addVec(0, NOP,    0, 0, 0, 0, E0, mRec(1, R_TYPE, 5), W0, 0, 0);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, wRec(1, R_TYPE, 5), 0, 0);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, W0, 1, 0);
    // Taken branch: sw behind beq is squashed, beq still retires
    addVec(1, BEQ,    0, 0, 0, 0, eRec(1, BEQ, 0), M0, W0, 1, 0);
    addVec(1, SW,     3, 0, 1, 1, E0, mRec(1, BEQ, 0), W0, 1, 1);
    addVec(0, NOP,    0, 0, 1, 0, E0, M0, wRec(1, BEQ, 0), 1, 1);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, W0, 2, 1);
    // Not-taken branch: sw follows through to W
    addVec(1, BEQ,    0, 0, 0, 0, eRec(1, BEQ, 0), M0, W0, 2, 1);
    addVec(1, SW,     3, 0, 0, 0, eRec(1, SW, 3), mRec(1, BEQ, 0), W0, 2, 1);
    addVec(0, NOP,    0, 0, 0, 0, E0, mRec(1, SW, 3), wRec(1, BEQ, 0), 2, 1);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, wRec(1, SW, 3), 3, 1);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, W0, 4, 1);
    // External flush with and without a valid Decode instruction
    addVec(1, LW,     7, 1, 0, 0, E0, M0, W0, 4, 2);
    addVec(0, LW,     7, 1, 0, 0, E0, M0, W0, 4, 2);
    // Flush and taken branch together count once
    addVec(1, BEQ,    0, 0, 0, 0, eRec(1, BEQ, 0), M0, W0, 4, 2);
    addVec(1, R_TYPE, 9, 1, 1, 1, E0, mRec(1, BEQ, 0), W0, 4, 3);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, wRec(1, BEQ, 0), 4, 3);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, W0, 5, 3);
    // Taken branch with an empty Decode slot does not count as a squash
    addVec(1, BEQ,    0, 0, 0, 0, eRec(1, BEQ, 0), M0, W0, 5, 3);
    addVec(0, NOP,    0, 0, 1, 1, E0, mRec(1, BEQ, 0), W0, 5, 3);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, wRec(1, BEQ, 0), 5, 3);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, W0, 6, 3);
    // All-zero control word retires; RegWrite to x0 is not masked
    addVec(1, NOP,    0, 0, 0, 0, eRec(1, NOP, 0), M0, W0, 6, 3);
    addVec(1, R_TYPE, 0, 0, 0, 0, eRec(1, R_TYPE, 0), mRec(1, NOP, 0), W0, 6, 3);
    addVec(0, NOP,    0, 0, 0, 0, E0, mRec(1, R_TYPE, 0), wRec(1, NOP, 0), 6, 3);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, wRec(1, R_TYPE, 0), 7, 3);
    addVec(0, NOP,    0, 0, 0, 0, E0, M0, W0, 8, 3);

    // Reset held for two cycles with a live-looking Decode instruction
    rst = 1'b1;
    driveD(1, R_TYPE, 5, 0, 1);
    #2 rst = 1'b0;
    #1 checkAllZero("rstAsync");
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 checkAllZero($sformatf("rstHold%0d", c));
    end
    @(negedge clk);
    driveD(0, NOP, 0, 0, 0);
    rst = 1'b1;

    foreach (vecQ[i]) applyStimulus(i, vecQ[i]);

    // Three instructions in flight, then asynchronous reset between edges
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      driveD(1, R_TYPE, 5'(i), 0, 0);
    end
    @(negedge clk);
    driveD(0, NOP, 0, 0, 0);
    #1;
    checkOutput("inflight.E", {3'b0, actE}, {3'b0, eRec(1, R_TYPE, 3)});
    checkOutput("inflight.W", {8'b0, actW}, {8'b0, wRec(1, R_TYPE, 1)});
    checkOutput("inflight.Retire", {12'b0, RetireCnt}, 16'd8);
    rst = 1'b0;
    #1;
    checkOutput("midRst.Valid", {13'b0, ValidE, ValidM, ValidW}, 16'h0);
    checkOutput("midRst.Retire", {12'b0, RetireCnt}, 16'h0);
    checkOutput("midRst.Squash", {12'b0, SquashCnt}, 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Sixteen retirements wrap the 4-bit counter back to zero
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      driveD(k <= 16, R_TYPE, 5'd4, 0, 0);
      @(posedge clk);
    end
    #1 checkOutput("wrap.Retire15", {12'b0, RetireCnt}, 16'd15);
    @(posedge clk);
    #1 checkOutput("wrap.Retire0", {12'b0, RetireCnt}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
